// File: rtl/window_filter_3x3.sv
// window_filter_3x3: streaming 3x3 filter (Sobel/Gaussian/pass-through/Sobel-threshold) between show-ahead FIFOs; ports: clock, reset (async, low), mode, threshold, in_rd_en/in_empty/in_dout, out_wr_en/out_full/out_din, frame_done
module window_filter_3x3 #(
  parameter int WIDTH = 720,
  parameter int HEIGHT = 540,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  frame_done
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int SW = DATA_WIDTH + 4;
  localparam logic [DATA_WIDTH-1:0] MAXV = '1;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [DATA_WIDTH-1:0] lb0 [WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [WIDTH];
  logic [DATA_WIDTH-1:0] w [3][3];
  logic [DATA_WIDTH-1:0] nw [3][3];
  logic [1:0] mode_q;
  logic [DATA_WIDTH-1:0] thr_q;
  logic out_valid, out_last, advance, x_end, y_end;
  logic signed [SW-1:0] gx, gy;
  logic [SW-1:0] mag, gsum;
  logic [DATA_WIDTH-1:0] sobel, res;
  function automatic logic signed [SW-1:0] s(input logic [DATA_WIDTH-1:0] p);
    return $signed({4'b0, p});
  endfunction
  function automatic logic [SW-1:0] u(input logic [DATA_WIDTH-1:0] p);
    return {4'b0, p};
  endfunction
  function automatic logic [SW-1:0] abs_s(input logic signed [SW-1:0] v);
    return v < 0 ? $unsigned(-v) : $unsigned(v);
  endfunction
  assign advance = reset && !in_empty && (!out_valid || !out_full);
  assign in_rd_en = advance;
  assign out_wr_en = out_valid && !out_full;
  assign frame_done = out_wr_en && out_last;
  assign x_end = x == XW'(WIDTH - 1);
  assign y_end = y == YW'(HEIGHT - 1);
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nw[r][0] = w[r][1];
      nw[r][1] = w[r][2];
    end
    nw[0][2] = lb1[x];
    nw[1][2] = lb0[x];
    nw[2][2] = in_dout;
    gx = s(nw[0][2]) + (s(nw[1][2]) <<< 1) + s(nw[2][2]) - s(nw[0][0]) - (s(nw[1][0]) <<< 1) - s(nw[2][0]);
    gy = s(nw[2][0]) + (s(nw[2][1]) <<< 1) + s(nw[2][2]) - s(nw[0][0]) - (s(nw[0][1]) <<< 1) - s(nw[0][2]);
    mag = (abs_s(gx) + abs_s(gy)) >> 1;
    sobel = mag > u(MAXV) ? MAXV : mag[DATA_WIDTH-1:0];
    gsum = u(nw[0][0]) + (u(nw[0][1]) << 1) + u(nw[0][2]) + (u(nw[1][0]) << 1) + (u(nw[1][1]) << 2)
         + (u(nw[1][2]) << 1) + u(nw[2][0]) + (u(nw[2][1]) << 1) + u(nw[2][2]);
    res = (x < XW'(2) || y < YW'(2)) ? '0 :
          mode_q == 2'd0 ? sobel :
          mode_q == 2'd1 ? gsum[SW-1:4] :
          mode_q == 2'd2 ? nw[1][1] :
          sobel >= thr_q ? MAXV : '0;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
      w <= '{default: '0};
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_din <= '0;
      mode_q <= '0;
      thr_q <= '0;
    end else if (advance) begin
      w <= nw;
      x <= x_end ? '0 : x + 1'b1;
      y <= x_end ? (y_end ? '0 : y + 1'b1) : y;
      if (x == '0 && y == '0) begin
        mode_q <= mode;
        thr_q <= threshold;
      end
      out_din <= res;
      out_valid <= 1'b1;
      out_last <= x_end && y_end;
    end else if (out_wr_en) begin
      out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (advance) begin
      lb1[x] <= lb0[x];
      lb0[x] <= in_dout;
    end
  end
endmodule

// File: tb/tb_window_filter_3x3.sv
// tb_window_filter_3x3: randomized scoreboard bench for window_filter_3x3 on an 8x6 image
module tb_window_filter_3x3;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
  typedef struct {int pix; int md; int th;} in_t;
  typedef struct {int v; bit last;} ex_t;
  logic clk = 0;
  logic rst_n = 1;
  logic [1:0] mode = 0;
  logic [7:0] threshold = 0;
  logic in_rd_en;
  logic in_empty = 1;
  logic [7:0] in_dout = 0;
  logic out_wr_en;
  logic out_full = 0;
  logic [7:0] out_din;
  logic frame_done;
  in_t src[$];
  ex_t exq[$];
  int img [H][W];
  int checks = 0;
  int fails = 0;
  int full_pct = 0;
  int empty_pct = 0;
  int pushes = 0;
  bit fire;
  window_filter_3x3 #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(8)) dut (
    .clock(clk), .reset(rst_n), .mode(mode), .threshold(threshold),
    .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  function automatic int golden(int x, int y, int md, int th);
    int p [3][3];
    int gx, gy, sb, g;
    if (x < 2 || y < 2) return 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) p[r][c] = img[y-2+r][x-2+c];
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    sb = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 2;
    if (sb > 255) sb = 255;
    g = (p[0][0] + 2*p[0][1] + p[0][2] + 2*p[1][0] + 4*p[1][1] + 2*p[1][2] + p[2][0] + 2*p[2][1] + p[2][2]) / 16;
    case (md)
      0: return sb;
      1: return g;
      2: return p[1][1];
      default: return sb >= th ? 255 : 0;
    endcase
  endfunction
  task automatic send_frame(int md, int th, int n = N, int sw_at = -1, int md2 = 0);
    for (int i = 0; i < n; i++) begin
      src.push_back(in_t'{img[i/W][i%W], (sw_at >= 0 && i >= sw_at) ? md2 : md, th});
      exq.push_back(ex_t'{golden(i % W, i / W, md, th), i == N - 1});
    end
  endtask
  task automatic fill_edge();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = x >= 4 ? 100 : 0;
  endtask
  task automatic fill_flat(int v);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = v;
  endtask
  task automatic fill_rand(bit extremes);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = extremes ? 255 * int'($urandom_range(1)) : int'($urandom_range(255));
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((src.size() != 0 || exq.size() != 0) && n < 4000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 4000) begin
      chk("drain_timeout_cycles", n, 0);
      src.delete();
      exq.delete();
    end
    repeat (3) @(posedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    fill_edge();
    send_frame(0, 0);
    @(negedge clk);
    #4;
    chk("rst_in_rd_en", in_rd_en, 0);
    chk("rst_out_wr_en", out_wr_en, 0);
    chk("rst_out_din", out_din, 0);
    chk("rst_frame_done", frame_done, 0);
    @(negedge clk);
    rst_n = 1;
  endtask
  initial forever begin
    @(negedge clk);
    if (src.size() > 0) begin
      in_dout = 8'(src[0].pix);
      mode = 2'(src[0].md);
      threshold = 8'(src[0].th);
    end
    in_empty = (src.size() == 0) || (int'($urandom_range(99)) < empty_pct);
    out_full = int'($urandom_range(99)) < full_pct;
    #4 fire = in_rd_en;
    @(posedge clk);
    if (fire) void'(src.pop_front());
  end
  initial forever begin
    @(negedge clk);
    #4;
    if (out_wr_en) begin
      if (exq.size() == 0) chk("unexpected_push", 1, 0);
      else begin
        ex_t e;
        e = exq.pop_front();
        chk($sformatf("out_din#%0d", pushes), int'(out_din), e.v);
        chk($sformatf("frame_done#%0d", pushes), int'(frame_done), int'(e.last));
      end
      pushes++;
    end
  end
  initial begin
    do_reset();
    wait_idle();
    fill_flat(80);
    send_frame(1, 0);
    wait_idle();
    fill_edge();
    send_frame(3, 150);
    send_frame(3, 201);
    wait_idle();
    full_pct = 50;
    empty_pct = 30;
    fill_edge();
    send_frame(0, 0);
    wait_idle();
    for (int k = 0; k < 6; k++) begin
      fill_rand(k % 2 == 1);
      send_frame(int'($urandom_range(3)), int'($urandom_range(255)));
    end
    wait_idle();
    full_pct = 0;
    empty_pct = 0;
    fill_rand(0);
    send_frame(2, 0, 21);
    wait_idle();
    do_reset();
    wait_idle();
    fill_edge();
    send_frame(0, 0, N, 10, 2);
    fill_rand(0);
    send_frame(2, 0);
    wait_idle();
    full_pct = 40;
    empty_pct = 40;
    fill_rand(1);
    send_frame(0, 0, N, 25, 3);
    fill_rand(0);
    send_frame(3, 90);
    wait_idle();
    chk("leftover_expected", exq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/window_filter_3x3.md
WINDOW_FILTER_3X3 -- requirements
Module: window_filter_3x3

Interface
REQ-001 SHALL have parameter WIDTH, default 720, image columns (3..2047).
REQ-002 SHALL have parameter HEIGHT, default 540, image rows (3..2047).
REQ-003 SHALL have parameter DATA_WIDTH, default 8, pixel bits (8..12).
REQ-004 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port mode  input  2  filter select: 0 Sobel, 1 Gaussian, 2 pass-through, 3 Sobel-threshold.
REQ-007 SHALL have port threshold  input  DATA_WIDTH  binarisation level for mode 3.
REQ-008 SHALL have port in_rd_en  output  1  pop request to upstream show-ahead FIFO.
REQ-009 SHALL have port in_empty  input  1  upstream FIFO empty.
REQ-010 SHALL have port in_dout  input  DATA_WIDTH  upstream pixel, valid while in_empty=0.
REQ-011 SHALL have port out_wr_en  output  1  push to downstream FIFO.
REQ-012 SHALL have port out_full  input  1  downstream FIFO full.
REQ-013 SHALL have port out_din  output  DATA_WIDTH  result pixel.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse on push of the frame's last pixel.

Function
REQ-015 SHALL keep two internal WIDTH-deep line-buffer RAMs (circular, column-indexed), no FIFO instances.
REQ-016 SHALL keep column counter x (0..WIDTH-1) and row counter y (0..HEIGHT-1), raster order.
REQ-017 SHALL define advance = !in_empty && (!out_valid || !out_full); in_rd_en = advance.
REQ-018 SHALL, on advance: shift 3x3 window left; load column 2 with {lb1[x], lb0[x], in_dout}; write lb1[x]<=lb0[x], lb0[x]<=in_dout.
REQ-019 SHALL compute result from the updated window combinationally, register into out_din with out_valid=1 on the advance cycle: latency 1 cycle, throughput 1 pixel/cycle.
REQ-020 SHALL assert out_wr_en = out_valid && !out_full; clear out_valid on push without simultaneous advance.
REQ-021 SHALL, on simultaneous push and advance, replace out_din with the new result, out_valid staying 1.
REQ-022 SHALL produce exactly WIDTH*HEIGHT outputs per frame, output i belonging to the window whose bottom-right pixel is input i.
REQ-023 SHALL output 0 when x<2 or y<2 (window incomplete), regardless of mode.
REQ-024 SHALL, mode 0: gx, gy standard Sobel kernels, signed DATA_WIDTH+4 bits; result=(|gx|+|gy|)>>1, saturated to 2^DATA_WIDTH-1.
REQ-025 SHALL, mode 1: weights 1 2 1 / 2 4 2 / 1 2 1, sum in DATA_WIDTH+4 bits, result=sum>>4 (truncate).
REQ-026 SHALL, mode 2: result = window centre pixel (row 1, column 1).
REQ-027 SHALL, mode 3: result = 2^DATA_WIDTH-1 if mode-0 value >= threshold, else 0.
REQ-028 SHALL sample mode and threshold into registers on the advance at x=0, y=0; changes mid-frame SHALL take effect next frame.
REQ-029 SHALL wrap x to 0 at WIDTH-1 and increment y; wrap y to 0 at HEIGHT-1 (next frame starts with no stall).
REQ-030 SHALL pulse frame_done with the out_wr_en of output WIDTH*HEIGHT-1.
REQ-031 SHALL hold all state when advance=0 and no push occurs; empty and full together stall indefinitely without loss.

Reset
REQ-032 SHALL, while reset=0: x=0, y=0, window=0, out_valid=0, out_din=0, out_wr_en=0, in_rd_en=0, frame_done=0, sampled mode=0, sampled threshold=0.
REQ-033 SHALL not require line-buffer RAM clearing; stale contents are masked by REQ-023.
REQ-034 SHALL, on reset mid-frame, discard the partial frame; first pixel after release is x=0, y=0.

Verification
REQ-035 Sobel edge: WIDTH=8, HEIGHT=6, DATA_WIDTH=8, mode 0, cols 0-3=0, cols 4-7=100 -> rows y>=2: outputs x=4,5 = 200, x=2,3,6,7 = 0; rows 0-1 all 0.
REQ-036 Gaussian flat: mode 1, all pixels 80 -> interior (x>=2,y>=2) = 80, border = 0; 48 pushes, frame_done on 48th.
REQ-037 Threshold: edge image of REQ-035, mode 3, threshold 150 -> x=4,5 = 255; threshold 201 -> all 0.
REQ-038 Backpressure: out_full toggled randomly 50%, in_empty randomly 30% -> output stream identical to REQ-035 golden, no drop or duplicate.
REQ-039 Mid-frame reset: reset=0 after 20 pixels, then full frame of REQ-035 -> output equals golden, no residue from partial frame.
REQ-040 Mode change: mode switched 0->2 at pixel 10 -> frame 1 all Sobel; frame 2 pass-through (output i = input i-WIDTH-1 for x>=2,y>=2).
